// File: rtl/traffic_intersection_ctrl.sv
// Two-approach (NS/EW) intersection controller with all-red clearance, latched
// pedestrian requests that truncate the conflicting green, and flashing-red mode.
module traffic_intersection_ctrl #(
    parameter int GREEN_CYCLES  = 20,
    parameter int YELLOW_CYCLES = 7,
    parameter int ALLRED_CYCLES = 2,
    parameter int MIN_REMAIN    = 5,
    parameter int FLASH_HALF    = 4,
    parameter int TIMER_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic ped_req_ns,
    input  logic ped_req_ew,
    input  logic flash,
    output logic red_ns,
    output logic yellow_ns,
    output logic green_ns,
    output logic red_ew,
    output logic yellow_ew,
    output logic green_ew,
    output logic walk_ns,
    output logic walk_ew,
    output logic flash_active
);

    localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MIN_LD    = TIMER_W'(MIN_REMAIN - 1);
    localparam logic [TIMER_W-1:0] FLASH_LD  = TIMER_W'(FLASH_HALF - 1);

    typedef enum logic [2:0] {
        ALLRED_A,
        NS_GREEN,
        NS_YELLOW,
        ALLRED_B,
        EW_GREEN,
        EW_YELLOW,
        FLASH
    } state_t;

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 flash_on, flash_on_nxt;
    logic                 ped_lat_ns, ped_lat_ns_nxt;
    logic                 ped_lat_ew, ped_lat_ew_nxt;
    logic                 walk_ns_nxt, walk_ew_nxt;
    logic                 truncate;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ALLRED_A;
            timer      <= ALLRED_LD;
            flash_on   <= 1'b0;
            ped_lat_ns <= 1'b0;
            ped_lat_ew <= 1'b0;
            walk_ns    <= 1'b0;
            walk_ew    <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            flash_on   <= flash_on_nxt;
            ped_lat_ns <= ped_lat_ns_nxt;
            ped_lat_ew <= ped_lat_ew_nxt;
            walk_ns    <= walk_ns_nxt;
            walk_ew    <= walk_ew_nxt;
        end
    end

    // A pending crossing request cuts the running conflicting green short, never lengthens it.
    assign truncate = ((state == NS_GREEN) && ped_lat_ew && (timer > MIN_LD)) ||
                      ((state == EW_GREEN) && ped_lat_ns && (timer > MIN_LD));

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        flash_on_nxt   = flash_on;
        ped_lat_ns_nxt = ped_lat_ns | ped_req_ns;
        ped_lat_ew_nxt = ped_lat_ew | ped_req_ew;
        walk_ns_nxt    = walk_ns;
        walk_ew_nxt    = walk_ew;

        if (enable) begin
            if (timer == '0) begin
                case (state)
                    ALLRED_A: begin
                        state_nxt = flash ? FLASH : NS_GREEN;
                        timer_nxt = flash ? FLASH_LD : GREEN_LD;
                    end
                    NS_GREEN: begin
                        state_nxt = NS_YELLOW;
                        timer_nxt = YELLOW_LD;
                    end
                    NS_YELLOW: begin
                        state_nxt = ALLRED_B;
                        timer_nxt = ALLRED_LD;
                    end
                    ALLRED_B: begin
                        state_nxt = flash ? FLASH : EW_GREEN;
                        timer_nxt = flash ? FLASH_LD : GREEN_LD;
                    end
                    EW_GREEN: begin
                        state_nxt = EW_YELLOW;
                        timer_nxt = YELLOW_LD;
                    end
                    EW_YELLOW: begin
                        state_nxt = ALLRED_A;
                        timer_nxt = ALLRED_LD;
                    end
                    FLASH: begin
                        // Leave only after a completed dark half so the reds never get clipped.
                        if (!flash_on && !flash) begin
                            state_nxt = ALLRED_A;
                            timer_nxt = ALLRED_LD;
                        end else begin
                            flash_on_nxt = ~flash_on;
                            timer_nxt    = FLASH_LD;
                        end
                    end
                    default: begin
                        state_nxt = ALLRED_A;
                        timer_nxt = ALLRED_LD;
                    end
                endcase
            end else if (truncate) begin
                timer_nxt = MIN_LD;
            end else begin
                timer_nxt = timer - 1'b1;
            end
        end

        if (state_nxt == FLASH && state != FLASH) begin
            flash_on_nxt = 1'b1;
        end

        if (state_nxt == NS_GREEN && state != NS_GREEN) begin
            walk_ns_nxt    = ped_lat_ns | ped_req_ns;
            ped_lat_ns_nxt = 1'b0;
        end else if (state == NS_GREEN && state_nxt != NS_GREEN) begin
            walk_ns_nxt = 1'b0;
        end

        if (state_nxt == EW_GREEN && state != EW_GREEN) begin
            walk_ew_nxt    = ped_lat_ew | ped_req_ew;
            ped_lat_ew_nxt = 1'b0;
        end else if (state == EW_GREEN && state_nxt != EW_GREEN) begin
            walk_ew_nxt = 1'b0;
        end
    end

    always_comb begin
        red_ns       = 1'b0;
        yellow_ns    = 1'b0;
        green_ns     = 1'b0;
        red_ew       = 1'b0;
        yellow_ew    = 1'b0;
        green_ew     = 1'b0;
        flash_active = 1'b0;
        case (state)
            NS_GREEN: begin
                green_ns = 1'b1;
                red_ew   = 1'b1;
            end
            NS_YELLOW: begin
                yellow_ns = 1'b1;
                red_ew    = 1'b1;
            end
            EW_GREEN: begin
                green_ew = 1'b1;
                red_ns   = 1'b1;
            end
            EW_YELLOW: begin
                yellow_ew = 1'b1;
                red_ns    = 1'b1;
            end
            FLASH: begin
                red_ns       = flash_on;
                red_ew       = flash_on;
                flash_active = 1'b1;
            end
            default: begin
                red_ns = 1'b1;
                red_ew = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: per-cycle expected lamp/walk
// vectors taken from the intended phase timeline are queued, then compared after each edge.
module tb_traffic_intersection_ctrl;

    logic clk;
    logic reset_n;
    logic enable;
    logic ped_req_ns;
    logic ped_req_ew;
    logic flash;
    logic red_ns, yellow_ns, green_ns;
    logic red_ew, yellow_ew, green_ew;
    logic walk_ns, walk_ew, flash_active;

    traffic_intersection_ctrl #(
        .GREEN_CYCLES (20),
        .YELLOW_CYCLES(7),
        .ALLRED_CYCLES(2),
        .MIN_REMAIN   (5),
        .FLASH_HALF   (4),
        .TIMER_W      (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .ped_req_ns  (ped_req_ns),
        .ped_req_ew  (ped_req_ew),
        .flash       (flash),
        .red_ns      (red_ns),
        .yellow_ns   (yellow_ns),
        .green_ns    (green_ns),
        .red_ew      (red_ew),
        .yellow_ew   (yellow_ew),
        .green_ew    (green_ew),
        .walk_ns     (walk_ns),
        .walk_ew     (walk_ew),
        .flash_active(flash_active)
    );

    // {red_ns, yellow_ns, green_ns, red_ew, yellow_ew, green_ew, walk_ns, walk_ew, flash_active}
    localparam logic [8:0] AR   = 9'b100_100_00_0;
    localparam logic [8:0] NSG  = 9'b001_100_00_0;
    localparam logic [8:0] NSY  = 9'b010_100_00_0;
    localparam logic [8:0] EWG  = 9'b100_001_00_0;
    localparam logic [8:0] EWY  = 9'b100_010_00_0;
    localparam logic [8:0] WNS  = 9'b000_000_10_0;
    localparam logic [8:0] WEW  = 9'b000_000_01_0;
    localparam logic [8:0] FON  = 9'b100_100_00_1;
    localparam logic [8:0] FOFF = 9'b000_000_00_1;

    logic [8:0] lamps;
    assign lamps = {red_ns, yellow_ns, green_ns, red_ew, yellow_ew, green_ew,
                    walk_ns, walk_ew, flash_active};

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Queue one expected vector per enabled/disabled edge, then compare after the edge.
    task automatic run(input string tag, input int n, input logic [8:0] e);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: scoreboard empty", tag);
            end else begin
                check_eq(tag, lamps, exp_q.pop_front());
            end
        end
    endtask

    task automatic base_cycle(input logic [8:0] ew_walk);
        run("ar_a", 1, AR);
        run("ns_green", 20, NSG);
        run("ns_yellow", 7, NSY);
        run("ar_b", 2, AR);
        run("ew_green", 20, EWG | ew_walk);
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        flash      = 1'b0;
        #3;
        check_eq("reset_hold", lamps, AR);
        #19;
        reset_n = 1'b1;
        #1;
        check_eq("reset_release", lamps, AR);

        // Nominal cycle from reset
        base_cycle('0);
        run("ew_yellow", 7, EWY);
        run("ar_a_end", 2, AR);

        // EW pedestrian pulse truncates NS green to five more cycles
        run("ns_green_pre", 5, NSG);
        ped_req_ew = 1'b1;
        run("ns_green_req", 1, NSG);
        ped_req_ew = 1'b0;
        run("ns_green_trunc", 5, NSG);
        run("ns_yellow", 7, NSY);
        run("ar_b", 2, AR);
        run("ew_green_walk", 20, EWG | WEW);
        run("ew_yellow", 7, EWY);
        run("ar_a", 2, AR);
        run("ns_green_full", 20, NSG);
        run("ns_yellow", 7, NSY);
        run("ar_b", 2, AR);
        run("ew_green_nowalk", 20, EWG);
        run("ew_yellow", 7, EWY);
        run("ar_a", 2, AR);

        // Freeze mid NS yellow; request latched while frozen
        run("ns_green", 20, NSG);
        run("ns_yellow_pre", 4, NSY);
        enable = 1'b0;
        run("frozen", 10, NSY);
        ped_req_ew = 1'b1;
        run("frozen_req", 1, NSY);
        ped_req_ew = 1'b0;
        run("frozen", 19, NSY);
        enable = 1'b1;
        run("ns_yellow_post", 3, NSY);
        run("ar_b", 2, AR);

        // Flash raised during EW green waits for the end of all-red
        run("ew_green_walk2", 10, EWG | WEW);
        flash = 1'b1;
        run("ew_green_flashreq", 10, EWG | WEW);
        run("ew_yellow", 7, EWY);
        run("ar_a_preflash", 2, AR);
        run("flash_on", 4, FON);
        run("flash_off", 4, FOFF);
        run("flash_on", 2, FON);
        flash = 1'b0;
        run("flash_on_tail", 2, FON);
        run("flash_off_tail", 4, FOFF);
        run("ar_a_postflash", 2, AR);
        run("ns_green", 20, NSG);

        // Async reset pulse while EW green shows walk
        ped_req_ew = 1'b1;
        run("ns_yellow", 1, NSY);
        ped_req_ew = 1'b0;
        run("ns_yellow", 6, NSY);
        run("ar_b", 2, AR);
        run("ew_green_walk3", 5, EWG | WEW);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset", lamps, AR);
        @(posedge clk);
        #4;
        check_eq("reset_over_edge", lamps, AR);
        reset_n = 1'b1;
        #1;
        check_eq("reset_release2", lamps, AR);
        base_cycle('0);
        run("ew_yellow", 7, EWY);

        // NS request held from entry into all-red A
        run("ar_a", 1, AR);
        ped_req_ns = 1'b1;
        run("ar_a", 1, AR);
        run("ns_green_walk", 20, NSG | WNS);
        ped_req_ns = 1'b0;
        run("ns_yellow", 7, NSY);
        run("ar_b", 2, AR);
        run("ew_green_trunc", 6, EWG);
        run("ew_yellow", 7, EWY);
        run("ar_a", 2, AR);
        run("ns_green_walk2", 20, NSG | WNS);
        run("ns_yellow", 1, NSY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Two-approach (NS/EW) intersection controller. It is the successor to the single-approach traffic light state machine.
- Phase durations are parameters.
- All-red clearance intervals separate the green phases.
- Pedestrian requests are latched, shorten the conflicting green, and drive walk signals.
- An enable input freezes the controller, and a safe-entry flashing-red mode is provided.
- Sits between the timing/sensor front end and the lamp drivers.

Parameters:
GREEN_CYCLES, 20, enabled cycles per green phase (≥1)
YELLOW_CYCLES, 7, enabled cycles per yellow phase (≥1)
ALLRED_CYCLES, 2, enabled cycles per all-red clearance (≥1)
MIN_REMAIN, 5, green cycles still served after a conflicting ped request truncates it (1..GREEN_CYCLES)
FLASH_HALF, 4, cycles per on/off half-period in flash mode (≥1)
TIMER_W, 8, phase timer width; must hold max(all durations)-1

Ports:
clk  in  1  clock, rising-edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = freeze state, timer and flash phase
ped_req_ns  in  1  pedestrian request to cross during NS green (pulse or level)
ped_req_ew  in  1  pedestrian request to cross during EW green
flash  in  1  request flashing-red mode
red_ns, yellow_ns, green_ns  out  1 each  NS lamps
red_ew, yellow_ew, green_ew  out  1 each  EW lamps
walk_ns, walk_ew  out  1 each  walk indication
flash_active  out  1  controller is in FLASH state

Behaviour:
- States: ALLRED_A → NS_GREEN → NS_YELLOW → ALLRED_B → EW_GREEN → EW_YELLOW → ALLRED_A. FLASH is reachable only from the end of ALLRED_A or ALLRED_B.
- Reset (async assert, sync deassert at next edge):
  - State = ALLRED_A; timer = ALLRED_CYCLES-1.
  - red_ns = red_ew = 1; all other outputs 0.
  - Ped latches 0; flash phase 0.
- Timer:
  - On entry to a phase of duration D, timer loads D-1.
  - Each enabled cycle: if timer==0, transition; else timer decrements.
  - A phase therefore lasts exactly D enabled cycles.
- Outputs are decoded from registered state/flags and change on the same edge as the state.
  - In GREEN/YELLOW states, only the active approach shows green/yellow; the other shows red.
  - ALLRED shows both red.
- enable=0: state, timer, flash counter and outputs hold.
  - Ped requests are still latched while enable=0.
  - Reset still acts.
- Ped latches:
  - ped_lat_x is set on any cycle ped_req_x=1.
  - On the edge entering X_GREEN: walk_x <= ped_lat_x | ped_req_x, and ped_lat_x <= 0.
  - walk_x stays constant for the whole X_GREEN and clears on the edge leaving it.
- Truncation:
  - While Y_GREEN is active (Y≠X), ped_lat_x=1 and timer > MIN_REMAIN-1, the next enabled edge loads timer = MIN_REMAIN-1 instead of decrementing.
  - A green is never lengthened.
  - No truncation occurs during yellow or all-red.
- Flash mode:
  - Entry: at an ALLRED timer==0 enabled edge with flash=1, go to FLASH (not the next green); flash phase loads on, counter = FLASH_HALF-1.
  - In FLASH: both reds equal the flash phase bit, all other lamps and walks are 0, and flash_active=1.
  - The phase toggles every FLASH_HALF enabled cycles.
  - Exit: when flash=0 at the end of an off half-period, go to ALLRED_A with a full ALLRED load.
  - flash asserted during green/yellow has no effect until the next all-red end.
- Simultaneous events:
  - Reset dominates everything.
  - A ped request arriving on the entry edge is served (see above).
  - A request for X that arrives during X_GREEN latches for the next X_GREEN.

Test Plan:
1. Reset release with enable=1, all other inputs 0 → both red for 2 cycles; NS green cycles 2–21, NS yellow 22–28, all-red 29–30, EW green 31–50, EW yellow 51–57, all-red 58–59; period = 58 cycles.
2. One-cycle ped_req_ew pulse when NS_GREEN timer=15 → NS green ends after 5 more enabled cycles; EW green is full 20 cycles with walk_ew=1 throughout, then the latch is clear; the following EW green has walk_ew=0.
3. enable=0 for 30 cycles mid-NS_YELLOW (timer=3) → lamps frozen on yellow_ns/red_ew; after re-enable, yellow lasts exactly 4 more cycles.
4. flash=1 raised during EW_GREEN → no effect until end of ALLRED_A. Then reds toggle 4 cycles on / 4 cycles off with all other lamps 0. Deassert flash mid-on half → exit to ALLRED_A (2 cycles both red) only after the off half completes, then NS_GREEN.
5. reset_n pulse (async, between edges) during EW_GREEN with walk_ew=1 → outputs immediately become red_ns=red_ew=1 with all others 0; sequence restarts exactly as scenario 1.
6. ped_req_ns held high from entry into ALLRED_A → walk_ns=1 for the entire NS_GREEN; no truncation of that NS green.
